// File: rtl/ramwr4_arb_if.sv
// Request/engine bus for ramwr4_arb: four requester write ports in, one RAM
// engine write port out, plus status.
interface ramwr4_arb_if #(
  parameter int unsigned ADDRBIT = 5,
  parameter int unsigned WIDTH   = 32
);
  logic                   active;
  logic [3:0]             req_we;
  logic [4*ADDRBIT-1:0]   req_wa;
  logic [4*WIDTH-1:0]     req_wrd;
  logic [3:0]             req_rdy;
  logic                   eng_we;
  logic [ADDRBIT-1:0]     eng_wa;
  logic [WIDTH-1:0]       eng_wrd;
  logic                   init_done;
  logic [3:0]             ovf_err;

  modport master (
    output active, req_we, req_wa, req_wrd,
    input  req_rdy, eng_we, eng_wa, eng_wrd, init_done, ovf_err
  );

  modport slave (
    input  active, req_we, req_wa, req_wrd,
    output req_rdy, eng_we, eng_wa, eng_wrd, init_done, ovf_err
  );
endinterface

// File: rtl/ramwr4_arb.sv
// Four-requester round-robin write arbiter feeding one RAM engine write port.
// Optional init sweep writing INITVAL to every address: define RAMWR4_ARB_INIT_EN.
module ramwr4_arb #(
  parameter int unsigned      ADDRBIT = 5,
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  ramwr4_arb_if.slave    bus
);

  localparam int unsigned NREQ = 4;

  logic [NREQ-1:0]    r_pend;
  logic [ADDRBIT-1:0] r_addr [NREQ];
  logic [WIDTH-1:0]   r_data [NREQ];
  logic [1:0]         r_rr_ptr;
  logic [NREQ-1:0]    r_ovf;
  logic               r_eng_we;
  logic [ADDRBIT-1:0] r_eng_wa;
  logic [WIDTH-1:0]   r_eng_wrd;

  logic               w_run;
  logic               w_init_we;
  logic [ADDRBIT-1:0] w_init_wa;
  logic [NREQ-1:0]    w_rdy;
  logic               w_gnt_vld;
  logic [1:0]         w_gnt_idx;

`ifdef RAMWR4_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDRBIT-1:0] r_sweep;
  logic [ADDRBIT-1:0] w_sweep_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // Sweep advances only while active; RUN is terminal until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (bus.active) begin
          w_init_we   = 1'b1;
          w_sweep_nxt = r_sweep + ADDRBIT'(1);
          if (&r_sweep) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_init_wa = r_sweep;
`else
  assign w_run     = 1'b1;
  assign w_init_we = 1'b0;
  assign w_init_wa = '0;
`endif

  assign w_rdy = ~r_pend & {NREQ{w_run}};

  // Search order rr_ptr+1 .. rr_ptr+4 (wraps back to rr_ptr last).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_vld && r_pend[2'(r_rr_ptr + 2'(k))]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 2'(r_rr_ptr + 2'(k));
      end
    end
    if (!(bus.active && w_run)) w_gnt_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_ovf    <= '0;
      r_rr_ptr <= 2'd3;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_we[i] && w_rdy[i])
          r_pend[i] <= 1'b1;
        else if (w_gnt_vld && (w_gnt_idx == 2'(i)))
          r_pend[i] <= 1'b0;
        if (bus.req_we[i] && !w_rdy[i])
          r_ovf[i] <= 1'b1;
      end
      if (w_gnt_vld) r_rr_ptr <= w_gnt_idx;
    end
  end

  // Slot payload only matters while pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_we[i] && w_rdy[i]) begin
        r_addr[i] <= bus.req_wa[i*ADDRBIT +: ADDRBIT];
        r_data[i] <= bus.req_wrd[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eng_we  <= 1'b0;
      r_eng_wa  <= '0;
      r_eng_wrd <= '0;
    end else if (w_init_we) begin
      r_eng_we  <= 1'b1;
      r_eng_wa  <= w_init_wa;
      r_eng_wrd <= INITVAL;
    end else if (w_gnt_vld) begin
      r_eng_we  <= 1'b1;
      r_eng_wa  <= r_addr[w_gnt_idx];
      r_eng_wrd <= r_data[w_gnt_idx];
    end else begin
      r_eng_we  <= 1'b0;
    end
  end

  assign bus.req_rdy   = w_rdy;
  assign bus.eng_we    = r_eng_we;
  assign bus.eng_wa    = r_eng_wa;
  assign bus.eng_wrd   = r_eng_wrd;
  assign bus.init_done = w_run;
  assign bus.ovf_err   = r_ovf;

endmodule

// File: tb/tb_ramwr4_arb.sv
// Self-checking bench for ramwr4_arb: directed scenarios with literal
// expectations plus a randomized run checked against a slot/queue model.
module tb_ramwr4_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  ramwr4_arb_if #(.ADDRBIT(AW), .WIDTH(DW)) bus ();

  ramwr4_arb #(.ADDRBIT(AW), .WIDTH(DW), .INITVAL('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: per-requester slots, rotating priority pointer.
  bit              m_valid = 1'b0;
  bit              m_pend [4];
  logic [AW-1:0]   m_addr [4];
  logic [DW-1:0]   m_data [4];
  int              m_ptr;
  bit [3:0]        m_ovf;
  bit              m_we;
  logic [AW-1:0]   m_wa;
  logic [DW-1:0]   m_wrd;
  bit              m_done;
  int              m_sweep;
  bit              rdy_pre [4];
  int              g;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 3; m_ovf = '0; m_we = 1'b0; m_wa = '0; m_wrd = '0; m_sweep = 0;
`ifdef RAMWR4_ARB_INIT_EN
      m_done = 1'b0;
`else
      m_done = 1'b1;
`endif
    end else if (m_valid) begin
      for (int i = 0; i < 4; i++) rdy_pre[i] = !m_pend[i] && m_done;
      g = -1;
      if (bus.active && m_done) begin
        for (int k = 1; k <= 4; k++)
          if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (!m_done && bus.active) begin
        m_we = 1'b1; m_wa = AW'(m_sweep); m_wrd = '0;
        if (m_sweep == (1 << AW) - 1) m_done = 1'b1;
        m_sweep++;
      end else if (g >= 0) begin
        m_we = 1'b1; m_wa = m_addr[g]; m_wrd = m_data[g];
        m_pend[g] = 1'b0; m_ptr = g;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.req_we[i]) begin
          if (rdy_pre[i]) begin
            m_pend[i] = 1'b1;
            m_addr[i] = bus.req_wa[i*AW +: AW];
            m_data[i] = bus.req_wrd[i*DW +: DW];
          end else begin
            m_ovf[i] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  logic [3:0] exp_rdy;
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 4; i++) exp_rdy[i] = !m_pend[i] && m_done;
      check("req_rdy",   64'(bus.req_rdy),   64'(exp_rdy));
      check("eng_we",    64'(bus.eng_we),    64'(m_we));
      check("eng_wa",    64'(bus.eng_wa),    64'(m_wa));
      check("eng_wrd",   64'(bus.eng_wrd),   64'(m_wrd));
      check("init_done", 64'(bus.init_done), 64'(m_done));
      check("ovf_err",   64'(bus.ovf_err),   64'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
`ifdef RAMWR4_ARB_INIT_EN
    bus.active = 1'b1;
    for (int n = 0; n < (1 << AW) + 8 && !bus.init_done; n++) cyc();
    check("init_done_timeout", 64'(bus.init_done), 64'd1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_we = '0;
    cyc();
    rst = 1'b0;
    wait_init();
  endtask

  int act_seq [5] = '{1, 0, 0, 1, 1};
  int stall_wa [3] = '{20, 21, 23};
  int n_st;

  initial begin
    bus.active  = 1'b0;
    bus.req_we  = '0;
    bus.req_wa  = '0;
    bus.req_wrd = '0;
    cyc();
    check("rst_eng_we", 64'(bus.eng_we), 64'd0);
    check("rst_eng_wa", 64'(bus.eng_wa), 64'd0);
    check("rst_ovf",    64'(bus.ovf_err), 64'd0);
    rst = 1'b0;
    wait_init();

    // Single write, no contention.
    bus.active = 1'b1;
    bus.req_wa[0*AW +: AW]  = AW'(5);
    bus.req_wrd[0*DW +: DW] = 32'hA5A5_A5A5;
    bus.req_we = 4'b0001;
    cyc();
    bus.req_we = '0;
    check("single_rdy_busy", 64'(bus.req_rdy), 64'hE);
    check("single_we_not_yet", 64'(bus.eng_we), 64'd0);
    cyc();
    check("single_we",  64'(bus.eng_we),  64'd1);
    check("single_wa",  64'(bus.eng_wa),  64'd5);
    check("single_wrd", 64'(bus.eng_wrd), 64'hA5A5_A5A5);
    check("single_rdy", 64'(bus.req_rdy), 64'hF);

    // Fairness with all four kept pending.
    do_reset();
    bus.active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_wa[i*AW +: AW]  = AW'(10 + i);
      bus.req_wrd[i*DW +: DW] = 32'hF000_0000 | 32'(i);
    end
    bus.req_we = 4'b1111;
    cyc();
    bus.req_we = bus.req_rdy;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("fair_we", 64'(bus.eng_we), 64'd1);
      check("fair_wa", 64'(bus.eng_wa), 64'(10 + k % 4));
      bus.req_we = bus.req_rdy;
    end
    bus.active = 1'b0;
    cyc();
    bus.req_we = '0;
    check("all_pend_rdy", 64'(bus.req_rdy), 64'h0);

    // Reset with every slot pending.
    rst = 1'b1;
    cyc();
    check("rstp_we",  64'(bus.eng_we),  64'd0);
    check("rstp_ovf", 64'(bus.ovf_err), 64'd0);
`ifdef RAMWR4_ARB_INIT_EN
    check("rstp_rdy", 64'(bus.req_rdy), 64'h0);
`else
    check("rstp_rdy", 64'(bus.req_rdy), 64'hF);
`endif
    rst = 1'b0;
    wait_init();

    // Overflow while inactive: second write lost.
    bus.active = 1'b0;
    bus.req_wa[2*AW +: AW]  = AW'(7);
    bus.req_wrd[2*DW +: DW] = 32'h111;
    bus.req_we = 4'b0100;
    cyc();
    bus.req_wrd[2*DW +: DW] = 32'h222;
    cyc();
    bus.req_we = '0;
    check("ovf_bits", 64'(bus.ovf_err), 64'h4);
    check("ovf_no_we", 64'(bus.eng_we), 64'd0);
    bus.active = 1'b1;
    cyc();
    check("ovf_we",  64'(bus.eng_we),  64'd1);
    check("ovf_wa",  64'(bus.eng_wa),  64'd7);
    check("ovf_wrd", 64'(bus.eng_wrd), 64'h111);
    cyc();
    check("ovf_lost", 64'(bus.eng_we), 64'd0);

    // Stall: grants only in active cycles, order 0,1,3.
    do_reset();
    bus.active = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_wa[i*AW +: AW] = AW'(20 + i);
    bus.req_we = 4'b1011;
    cyc();
    bus.req_we = '0;
    check("stall_rdy", 64'(bus.req_rdy), 64'h4);
    n_st = 0;
    for (int j = 0; j < 5; j++) begin
      bus.active = act_seq[j][0];
      cyc();
      check("stall_we", 64'(bus.eng_we), 64'(act_seq[j]));
      if (act_seq[j] != 0) begin
        check("stall_wa", 64'(bus.eng_wa), 64'(stall_wa[n_st]));
        n_st++;
      end
    end

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      bus.active = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        bus.req_wa[i*AW +: AW]  = AW'($urandom);
        bus.req_wrd[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) bus.req_we = 4'($urandom);
      else                          bus.req_we = 4'($urandom) & bus.req_rdy;
      cyc();
    end
    rst = 1'b0;
    bus.req_we = '0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ramwr4_arb.md
RAMWR4_ARB -- requirements
Module: ramwr4_arb

Interface
REQ-001 Parameter ADDRBIT, default 5, RAM address width.
REQ-002 Parameter WIDTH, default 32, RAM data width.
REQ-003 Parameter INITVAL, default 0 (WIDTH bits), data written by the init sweep.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 active  input  1  engine enable; arbitration and init sweep advance only while 1.
REQ-007 req_we  input  4  per-requester write strobe, bit i = requester i.
REQ-008 req_wa  input  4*ADDRBIT  write addresses; requester i in slice [i*ADDRBIT +: ADDRBIT].
REQ-009 req_wrd  input  4*WIDTH  write data; requester i in slice [i*WIDTH +: WIDTH].
REQ-010 req_rdy  output  4  bit i = 1 when requester i's holding slot is free.
REQ-011 eng_we  output  1  registered write strobe to the RAM engine write port.
REQ-012 eng_wa  output  ADDRBIT  registered write address.
REQ-013 eng_wrd  output  WIDTH  registered write data.
REQ-014 init_done  output  1  1 once the init sweep is complete (or compiled out).
REQ-015 ovf_err  output  4  sticky; bit i set when requester i writes while its slot is full.

Function
REQ-016 Each requester owns one holding slot (pend[i], addr, data): req_rdy[i] = ~pend[i] & init_done.
REQ-017 req_we[i] & req_rdy[i] at edge t captures req_wa/req_wrd slice i and sets pend[i].
REQ-018 req_we[i] & ~req_rdy[i] drops the write, sets ovf_err[i], and leaves the slot unchanged.
REQ-019 Grant rule: round-robin over pend[] in the order rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4); rr_ptr holds the last granted index.
REQ-020 A grant occurs in any cycle with active=1, state RUN and |pend=1; otherwise there is no grant.
REQ-021 Grant to i at edge t clears pend[i], sets rr_ptr=i, and registers eng_we=1, eng_wa=slot addr, eng_wrd=slot data.
REQ-022 With no grant, eng_we=0 and eng_wa/eng_wrd hold their previous values.
REQ-023 Latency: req_we sampled at edge t; with no contention, eng_we is high after edge t+1 (visible one cycle after capture).
REQ-024 Slot freed by a grant is req_rdy=1 the following cycle; capture and grant of the same slot never occur at the same edge.
REQ-025 active=0: no grants, pend/slots held, captures still accepted into free slots.
REQ-026 Throughput: one write per cycle; 4 saturated requesters each receive exactly 1 grant per 4 cycles.
REQ-027 Same-address writes from different requesters are not merged; they issue in grant order.
REQ-028 FSM states INIT and RUN; INIT->RUN after the last sweep write; RUN is terminal until rst.

Reset
REQ-029 rst clears pend[3:0], ovf_err=0, eng_we=0, eng_wa=0, eng_wrd=0, and sets rr_ptr=3 (requester 0 first).
REQ-030 rst mid-sweep or mid-burst discards all pending writes and restarts per REQ-031/032.

Configuration
REQ-031 With RAMWR4_ARB_INIT_EN defined: after rst, state=INIT, init_done=0, req_rdy=0; each cycle with active=1 issues eng_we=1, eng_wa=sweep counter, eng_wrd=INITVAL, counter 0 up to 2^ADDRBIT-1; after the last write, state=RUN, init_done=1.
REQ-032 Without RAMWR4_ARB_INIT_EN: after rst, state=RUN, init_done=1; no sweep logic is present.
REQ-033 During INIT, req_we pulses set ovf_err (slots are not ready).

Verification
REQ-034 Single: req_we=0001, wa=5, wrd=0xA5A5A5A5 -> eng_we=1, wa=5, wrd=0xA5A5A5A5 one cycle after capture; req_rdy[0] back to 1.
REQ-035 Fairness: all 4 held pending with active=1 -> grant order 0,1,2,3,0,... for 8 cycles; eng_we held high continuously.
REQ-036 Overflow: requester 2 writes twice while active=0 -> ovf_err=0100; first data issued after active=1; second write lost.
REQ-037 Stall: pend=1011, active toggles 1,0,0,1,1 -> grants only in the active=1 cycles, order 0,1,3.
REQ-038 INIT_EN, ADDRBIT=3, INITVAL=0 -> 8 writes to addresses 0..7 with data 0; init_done rises after address 7; active=0 mid-sweep pauses the counter.
REQ-039 rst asserted with pend=1111 -> next cycle pend=0, eng_we=0, req_rdy=1111 (no INIT_EN).
